// File: rtl/apb3_master_bridge.sv
// APB3 initiator: takes one command at a time from the CPU-side port, runs a
// SETUP/ACCESS transfer on the selected slave and returns the result.
module apb3_master_bridge #(
  parameter int NUM_SLAVES = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic                       io_apb_PCLK,
  input  logic                       io_apb_PRESETn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [19:0]                cmd_addr,
  input  logic                       cmd_write,
  input  logic [31:0]                cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_error,
  output logic                       rsp_timeout,
  output logic [15:0]                io_apb_PADDR,
  output logic [NUM_SLAVES-1:0]      io_apb_PSEL,
  output logic                       io_apb_PENABLE,
  output logic                       io_apb_PWRITE,
  output logic [31:0]                io_apb_PWDATA,
  input  logic [NUM_SLAVES-1:0]      io_apb_PREADY,
  input  logic [32*NUM_SLAVES-1:0]   io_apb_PRDATA,
  input  logic [NUM_SLAVES-1:0]      io_apb_PSLVERROR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                  state_reg;
  logic [CW-1:0]           cnt_reg;
  logic [NUM_SLAVES-1:0]   psel_reg;
  logic                    penable_reg;
  logic                    pwrite_reg;
  logic [15:0]             paddr_reg;
  logic [31:0]             pwdata_reg;
  logic                    rsp_valid_reg;
  logic [31:0]             rsp_rdata_reg;
  logic                    rsp_error_reg;
  logic                    rsp_timeout_reg;

  logic [NUM_SLAVES-1:0]   dec_hot;
  logic [31:0]             rdata_acc [NUM_SLAVES+1];
  logic [31:0]             sel_rdata;
  logic                    sel_ready;
  logic                    sel_err;
  logic                    timeout_hit;

  // One-hot decode of the slave index; an all-zero result is a decode error.
  // The read-data mux reuses the registered select so only that slave is seen.
  assign rdata_acc[0] = 32'h0;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign dec_hot[gi]     = (cmd_addr[19:16] == 4'(gi));
      assign rdata_acc[gi+1] = rdata_acc[gi] |
                               (io_apb_PRDATA[32*gi +: 32] & {32{psel_reg[gi]}});
    end
  endgenerate

  assign sel_rdata = rdata_acc[NUM_SLAVES];
  assign sel_ready = |(io_apb_PREADY & psel_reg);
  assign sel_err   = |(io_apb_PSLVERROR & psel_reg);

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge io_apb_PCLK or negedge io_apb_PRESETn) begin
    if (!io_apb_PRESETn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      psel_reg        <= '0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= 16'h0;
      pwdata_reg      <= 32'h0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= 32'h0;
      rsp_error_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            paddr_reg  <= cmd_addr[15:0];
            pwrite_reg <= cmd_write;
            pwdata_reg <= cmd_wdata;
            cnt_reg    <= '0;
            if (|dec_hot) begin
              psel_reg  <= dec_hot;
              state_reg <= SETUP;
            end else begin
              rsp_valid_reg   <= 1'b1;
              rsp_error_reg   <= 1'b1;
              rsp_rdata_reg   <= 32'h0;
              rsp_timeout_reg <= 1'b0;
              state_reg       <= RESP;
            end
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          // Ready on the final permitted cycle wins over the timeout.
          if (sel_ready) begin
            psel_reg        <= '0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_error_reg   <= sel_err;
            rsp_rdata_reg   <= (!pwrite_reg && !sel_err) ? sel_rdata : 32'h0;
            rsp_timeout_reg <= 1'b0;
            state_reg       <= RESP;
          end else if (timeout_hit) begin
            psel_reg        <= '0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_error_reg   <= 1'b1;
            rsp_rdata_reg   <= 32'h0;
            rsp_timeout_reg <= 1'b1;
            state_reg       <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Gated by reset so the port reads 0 while reset is held.
  assign cmd_ready      = io_apb_PRESETn && (state_reg == IDLE);
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_rdata      = rsp_rdata_reg;
  assign rsp_error      = rsp_error_reg;
  assign rsp_timeout    = rsp_timeout_reg;
  assign io_apb_PADDR   = paddr_reg;
  assign io_apb_PSEL    = psel_reg;
  assign io_apb_PENABLE = penable_reg;
  assign io_apb_PWRITE  = pwrite_reg;
  assign io_apb_PWDATA  = pwdata_reg;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Directed bench for apb3_master_bridge with 8 slaves and a 4-cycle timeout.
module tb_apb3_master_bridge;

  localparam int NS = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [19:0]     cmd_addr;
  logic            cmd_write;
  logic [31:0]     cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_error;
  logic            rsp_timeout;
  logic [15:0]     paddr;
  logic [NS-1:0]   psel;
  logic            penable;
  logic            pwrite;
  logic [31:0]     pwdata;
  logic [NS-1:0]   pready;
  logic [32*NS-1:0] prdata;
  logic [NS-1:0]   perr;

  int checks = 0;
  int errors = 0;

  apb3_master_bridge #(.NUM_SLAVES(NS), .TIMEOUT(4)) dut (
    .io_apb_PCLK      (clk),
    .io_apb_PRESETn   (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_addr         (cmd_addr),
    .cmd_write        (cmd_write),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .rsp_timeout      (rsp_timeout),
    .io_apb_PADDR     (paddr),
    .io_apb_PSEL      (psel),
    .io_apb_PENABLE   (penable),
    .io_apb_PWRITE    (pwrite),
    .io_apb_PWDATA    (pwdata),
    .io_apb_PREADY    (pready),
    .io_apb_PRDATA    (prdata),
    .io_apb_PSLVERROR (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a command at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [19:0] a, input logic w, input logic [31:0] d);
    chk("cmd_ready_before_issue", {31'b0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_dropped", {31'b0, rsp_valid}, 32'h0);
    chk("cmd_ready_back", {31'b0, cmd_ready}, 32'h1);
  endtask

  int acc;
  int accepts;
  int spurious;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    pready    = '0;
    prdata    = '0;
    perr      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    chk("reset_psel", {24'b0, psel}, 32'h0);
    chk("reset_penable", {31'b0, penable}, 32'h0);
    chk("reset_paddr", {16'b0, paddr}, 32'h0);
    chk("reset_pwdata", pwdata, 32'h0);
    chk("reset_pwrite", {31'b0, pwrite}, 32'h0);
    chk("reset_rsp", {29'b0, rsp_valid, rsp_error, rsp_timeout}, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'h1);

    // Read, slave 2, zero waits; other slaves show noise that must be ignored
    prdata[32*2 +: 32] = 32'hDEADBEEF;
    prdata[32*3 +: 32] = 32'h55555555;
    pready = 8'b0000_0100;
    perr   = 8'b1111_1011;
    issue(20'h2_0008, 1'b0, 32'h0);
    chk("rd_setup_psel", {24'b0, psel}, 32'h4);
    chk("rd_setup_penable", {31'b0, penable}, 32'h0);
    chk("rd_setup_paddr", {16'b0, paddr}, 32'h0008);
    chk("rd_setup_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    @(negedge clk);
    chk("rd_access_psel", {24'b0, psel}, 32'h4);
    chk("rd_access_penable", {31'b0, penable}, 32'h1);
    chk("rd_access_no_rsp", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk);
    chk("rd_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("rd_rsp_bus_idle", {23'b0, psel, penable}, 32'h0);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_flags", {30'b0, rsp_error, rsp_timeout}, 32'h0);
    pready = '0;
    perr   = '0;
    release_rsp();

    // Write, slave 1, three wait states (ready on the 4th ACCESS cycle)
    prdata[32*1 +: 32] = 32'hFFFF0000;
    issue(20'h1_0004, 1'b1, 32'h12345678);
    chk("wr_setup_psel", {24'b0, psel}, 32'h2);
    chk("wr_setup_pwrite", {31'b0, pwrite}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("wr_access%0d_en", i), {23'b0, psel, penable}, 32'h5);
      chk($sformatf("wr_access%0d_paddr", i), {16'b0, paddr}, 32'h0004);
      chk($sformatf("wr_access%0d_pwdata", i), pwdata, 32'h12345678);
      if (i == 4) pready = 8'b0000_0010;
    end
    @(negedge clk);
    pready = '0;
    chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_rsp_flags", {30'b0, rsp_error, rsp_timeout}, 32'h0);
    release_rsp();
    chk("wr_pwdata_held", pwdata, 32'h12345678);

    // Slave error on a read, slave 5
    prdata[32*5 +: 32] = 32'hCAFEF00D;
    pready = 8'b0010_0000;
    perr   = 8'b0010_0000;
    issue(20'h5_0010, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk("serr_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("serr_rsp_error", {31'b0, rsp_error}, 32'h1);
    chk("serr_rsp_timeout", {31'b0, rsp_timeout}, 32'h0);
    chk("serr_rsp_rdata", rsp_rdata, 32'h0);
    pready = '0;
    perr   = '0;
    release_rsp();

    // Timeout: slave 0 never ready
    prdata[32*0 +: 32] = 32'h01234567;
    issue(20'h0_0020, 1'b0, 32'h0);
    acc = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(negedge clk);
      if (penable) acc++;
    end
    chk("to_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("to_access_cycles", acc, 32'd4);
    chk("to_flags", {30'b0, rsp_error, rsp_timeout}, 32'h3);
    chk("to_rdata", rsp_rdata, 32'h0);
    chk("to_psel", {24'b0, psel}, 32'h0);
    release_rsp();

    // Ready on the last permitted ACCESS cycle completes normally, slave 3
    prdata[32*3 +: 32] = 32'hA5A5_1234;
    issue(20'h3_0100, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) pready = 8'b0000_1000;
    end
    @(negedge clk);
    pready = '0;
    chk("edge_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("edge_flags", {30'b0, rsp_error, rsp_timeout}, 32'h0);
    chk("edge_rdata", rsp_rdata, 32'hA5A51234);
    release_rsp();

    // Decode error, index 10; response held for 5 cycles
    issue(20'hA_0000, 1'b0, 32'h0);
    chk("dec_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("dec_flags", {30'b0, rsp_error, rsp_timeout}, 32'h2);
    chk("dec_rdata", rsp_rdata, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("dec_hold%0d", i),
          {21'b0, psel, penable, cmd_ready, rsp_valid, rsp_error}, 32'h3);
    end
    release_rsp();

    // Back-to-back with rsp_ready and PREADY high: one accept every 4 cycles
    pready    = '1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr  = 20'h4_0000;
    cmd_write = 1'b1;
    accepts   = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready) accepts++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", accepts, 32'd3);
    chk("b2b_drained", {31'b0, cmd_ready}, 32'h1);
    rsp_ready = 1'b0;
    pready    = '0;

    // Reset during an ACCESS wait state
    issue(20'h1_0040, 1'b1, 32'h87654321);
    @(negedge clk);
    chk("rst_mid_in_access", {31'b0, penable}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", {23'b0, psel, penable}, 32'h0);
    chk("rst_mid_paddr_pwdata", {16'b0, paddr} | pwdata, 32'h0);
    chk("rst_mid_ctrl", {30'b0, cmd_ready, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) spurious++;
    end
    chk("rst_no_rsp", spurious, 32'd0);

    prdata[32*6 +: 32] = 32'h0BADF00D;
    pready = 8'b0100_0000;
    issue(20'h6_00FC, 1'b0, 32'h0);
    chk("post_rst_psel", {24'b0, psel}, 32'h40);
    repeat (2) @(negedge clk);
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("post_rst_rdata", rsp_rdata, 32'h0BADF00D);
    chk("post_rst_flags", {30'b0, rsp_error, rsp_timeout}, 32'h0);
    pready = '0;
    release_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
